// File: rtl/io_bridge.sv
// io_bridge: memory-mapped bridge between the processor bus and RAM/peripherals.
// Peripherals: LED register, scanned 4-digit 7-segment display, synchronised switches,
// and an optional interval timer built only when IO_TIMER_EN is defined.
// Read data returns on DIN one cycle after the address, matching the synchronous RAM.
module io_bridge #(
  parameter int TICK_DIV  = 50000,
  parameter int SCAN_BITS = 16
) (
  input  logic        clk_50MHz,
  input  logic        reset,
  input  logic [7:0]  ADDR,
  input  logic [15:0] DOUT,
  input  logic        W,
  input  logic [15:0] mem_q,
  input  logic [9:0]  SW,
  output logic        mem_wren,
  output logic [15:0] DIN,
  output logic [9:0]  LEDR,
  output logic [6:0]  seg_n,
  output logic [3:0]  an_n,
  output logic        timer_irq
);

  localparam logic [7:0] A_LED   = 8'h80;
  localparam logic [7:0] A_HEX   = 8'h90;
  localparam logic [7:0] A_SW    = 8'hA0;
  localparam logic [7:0] A_TLOAD = 8'hB0;
  localparam logic [7:0] A_TCTRL = 8'hB1;
  localparam logic [7:0] A_TSTAT = 8'hB2;

  // Active-low hex decode, bit order {g,f,e,d,c,b,a}
  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'b1000000;
      4'h1: hex7 = 7'b1111001;
      4'h2: hex7 = 7'b0100100;
      4'h3: hex7 = 7'b0110000;
      4'h4: hex7 = 7'b0011001;
      4'h5: hex7 = 7'b0010010;
      4'h6: hex7 = 7'b0000010;
      4'h7: hex7 = 7'b1111000;
      4'h8: hex7 = 7'b0000000;
      4'h9: hex7 = 7'b0010000;
      4'hA: hex7 = 7'b0001000;
      4'hB: hex7 = 7'b0000011;
      4'hC: hex7 = 7'b1000110;
      4'hD: hex7 = 7'b0100001;
      4'hE: hex7 = 7'b0000110;
      default: hex7 = 7'b0001110;
    endcase
  endfunction

  logic [15:0]          hex_q;
  logic [9:0]           sw_s1, sw_s2;
  logic [SCAN_BITS-1:0] scan_cnt;
  logic [1:0]           digit;
  logic [3:0]           nib;
  logic [15:0]          rd_val;
  logic                 ram_sel_p0;
  logic [15:0]          rd_val_p0;

  assign mem_wren = W & ~ADDR[7];

`ifdef IO_TIMER_EN
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [PW-1:0] presc;
  logic [15:0]   t_reload, t_count;
  logic          t_en, t_auto, t_exp;
  logic          tick, expire;

  assign tick      = t_en && (presc == PW'(TICK_DIV - 1));
  assign expire    = tick && (t_count <= 16'd1);
  assign timer_irq = t_exp;

  // Timer: prescaler, down-counter, expiry flag; bus writes override a same-cycle tick
  always_ff @(posedge clk_50MHz) begin
    if (reset) begin
      presc    <= '0;
      t_reload <= '0;
      t_count  <= '0;
      t_en     <= 1'b0;
      t_auto   <= 1'b0;
      t_exp    <= 1'b0;
    end else begin
      if (t_en) presc <= tick ? '0 : presc + 1'b1;
      if (tick) begin
        if (expire) begin
          t_exp <= 1'b1;
          if (t_auto) begin
            t_count <= t_reload;
          end else begin
            t_count <= '0;
            t_en    <= 1'b0;
          end
        end else begin
          t_count <= t_count - 16'd1;
        end
      end
      // A clear racing with expiry loses so no expiry is ever missed
      if (W && ADDR == A_TSTAT && DOUT[0] && !expire) t_exp <= 1'b0;
      if (W && ADDR == A_TLOAD) begin
        t_reload <= DOUT;
        t_count  <= DOUT;
        presc    <= '0;
      end
      if (W && ADDR == A_TCTRL) begin
        t_en   <= DOUT[0];
        t_auto <= DOUT[1];
        if (DOUT[0] && !t_en) presc <= '0;
      end
    end
  end
`else
  assign timer_irq = 1'b0;
`endif

  // Peripheral read value for the address presented this cycle
  always_comb begin
    rd_val = '0;
    case (ADDR)
      A_LED:   rd_val = {6'b0, LEDR};
      A_HEX:   rd_val = hex_q;
      A_SW:    rd_val = {6'b0, sw_s2};
`ifdef IO_TIMER_EN
      A_TLOAD: rd_val = t_count;
      A_TCTRL: rd_val = {14'b0, t_auto, t_en};
      A_TSTAT: rd_val = {15'b0, t_exp};
`endif
      default: rd_val = '0;
    endcase
  end

  // LED and HEX registers written on the strobe edge
  always_ff @(posedge clk_50MHz) begin
    if (reset) begin
      LEDR  <= '0;
      hex_q <= '0;
    end else begin
      if (W && ADDR == A_LED) LEDR  <= DOUT[9:0];
      if (W && ADDR == A_HEX) hex_q <= DOUT;
    end
  end

  // Two-flop synchroniser for the asynchronous switches
  always_ff @(posedge clk_50MHz) begin
    if (reset) begin
      sw_s1 <= '0;
      sw_s2 <= '0;
    end else begin
      sw_s1 <= SW;
      sw_s2 <= sw_s1;
    end
  end

  // ---- stage p0: register region select and peripheral read value ----
  // Region and read value captured each cycle; unmapped (zero) after reset
  always_ff @(posedge clk_50MHz) begin
    if (reset) begin
      ram_sel_p0 <= 1'b0;
      rd_val_p0  <= '0;
    end else begin
      ram_sel_p0 <= ~ADDR[7];
      rd_val_p0  <= rd_val;
    end
  end

  assign DIN = ram_sel_p0 ? mem_q : rd_val_p0;

  assign digit = scan_cnt[SCAN_BITS-1 -: 2];
  assign nib   = hex_q[{digit, 2'b00} +: 4];

  // Display scan: free-running counter drives registered digit enable and segments
  always_ff @(posedge clk_50MHz) begin
    if (reset) begin
      scan_cnt <= '0;
      an_n     <= 4'b1110;
      seg_n    <= 7'b1000000;
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
      an_n     <= ~(4'b0001 << digit);
      seg_n    <= hex7(nib);
    end
  end

endmodule

// File: tb/tb_io_bridge.sv
// Directed bench for io_bridge (TICK_DIV=4, SCAN_BITS=4); timer checks follow IO_TIMER_EN.
module tb_io_bridge;

  logic        clk_50MHz = 1'b0;
  logic        reset;
  logic [7:0]  ADDR;
  logic [15:0] DOUT;
  logic        W;
  logic [15:0] mem_q;
  logic [9:0]  SW;
  logic        mem_wren;
  logic [15:0] DIN;
  logic [9:0]  LEDR;
  logic [6:0]  seg_n;
  logic [3:0]  an_n;
  logic        timer_irq;

  int n_total = 0;
  int n_bad   = 0;
  int unsigned cyc = 0;
  logic [15:0] ram [0:127];
  logic [6:0]  seg_tab [0:3] = '{7'h0E, 7'h08, 7'h24, 7'h79};
  logic [3:0]  an_tab  [0:3] = '{4'hE, 4'hD, 4'hB, 4'h7};

  io_bridge #(.TICK_DIV(4), .SCAN_BITS(4)) dut (
    .clk_50MHz (clk_50MHz),
    .reset     (reset),
    .ADDR      (ADDR),
    .DOUT      (DOUT),
    .W         (W),
    .mem_q     (mem_q),
    .SW        (SW),
    .mem_wren  (mem_wren),
    .DIN       (DIN),
    .LEDR      (LEDR),
    .seg_n     (seg_n),
    .an_n      (an_n),
    .timer_irq (timer_irq)
  );

  always #5 clk_50MHz = ~clk_50MHz;

  // Synchronous RAM model with one-cycle read latency
  initial for (int i = 0; i < 128; i++) ram[i] = 16'h0000;
  always @(posedge clk_50MHz) begin
    if (mem_wren) ram[ADDR[6:0]] <= DOUT;
    mem_q <= ram[ADDR[6:0]];
  end

  // Clock count since reset, tracks the display scan phase
  always @(posedge clk_50MHz) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic bus_write(input logic [7:0] a, input logic [15:0] d);
    @(negedge clk_50MHz);
    ADDR = a; DOUT = d; W = 1'b1;
    @(negedge clk_50MHz);
    W = 1'b0;
  endtask

  task automatic bus_read(input logic [7:0] a, output logic [15:0] d);
    @(negedge clk_50MHz);
    ADDR = a; W = 1'b0;
    @(negedge clk_50MHz);
    d = DIN;
  endtask

  initial begin
    logic [15:0] rd;
    int d;
    reset = 1'b1; ADDR = 8'h00; DOUT = 16'h0000; W = 1'b0; SW = 10'h000;
    repeat (3) @(negedge clk_50MHz);
    check("rst_ledr", LEDR, 10'h000);
    check("rst_an", an_n, 4'b1110);
    check("rst_seg", seg_n, 7'b1000000);
    check("rst_din", DIN, 16'h0000);
    check("rst_irq", timer_irq, 1'b0);
    reset = 1'b0;

    // LED write and readback
    @(negedge clk_50MHz);
    ADDR = 8'h80; DOUT = 16'h03A5; W = 1'b1;
    #1 check("wren_led", mem_wren, 1'b0);
    @(negedge clk_50MHz);
    W = 1'b0;
    check("ledr", LEDR, 10'h3A5);
    bus_read(8'h80, rd); check("rd_led", rd, 16'h03A5);

    // RAM write strobe and read through
    @(negedge clk_50MHz);
    ADDR = 8'h12; DOUT = 16'hBEEF; W = 1'b1;
    #1 check("wren_ram", mem_wren, 1'b1);
    @(negedge clk_50MHz);
    W = 1'b0;
    bus_read(8'h12, rd); check("rd_ram12", rd, 16'hBEEF);

    // Switch synchroniser: value visible on the third read cycle
    @(negedge clk_50MHz);
    SW = 10'h155; ADDR = 8'hA0;
    @(negedge clk_50MHz); check("sw_e1", DIN, 16'h0000);
    @(negedge clk_50MHz); check("sw_e2", DIN, 16'h0000);
    @(negedge clk_50MHz); check("sw_e3", DIN, 16'h0155);

    // Back-to-back reads of RAM then switches
    @(negedge clk_50MHz); ADDR = 8'h12;
    @(negedge clk_50MHz); check("b2b_ram", DIN, 16'hBEEF); ADDR = 8'hA0;
    @(negedge clk_50MHz); check("b2b_sw", DIN, 16'h0155);

    bus_write(8'h55, 16'h1234);
    bus_read(8'h55, rd); check("rd_ram55", rd, 16'h1234);
    bus_write(8'hC0, 16'hFFFF);
    check("unmapped_wr", LEDR, 10'h3A5);
    bus_read(8'hC0, rd); check("rd_c0", rd, 16'h0000);

    // Display scan
    bus_write(8'h90, 16'h12AF);
    bus_read(8'h90, rd); check("rd_hex", rd, 16'h12AF);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk_50MHz);
      d = int'(((cyc - 1) % 16) >> 2);
      check("an_n", an_n, an_tab[d]);
      check("seg_n", seg_n, seg_tab[d]);
    end

`ifdef IO_TIMER_EN
    // One-shot: load 3, enable; expires 12 clocks after the enable edge
    bus_write(8'hB0, 16'd3);
    bus_write(8'hB1, 16'h0001);
    repeat (11) @(negedge clk_50MHz);
    check("t1_pre", timer_irq, 1'b0);
    @(negedge clk_50MHz);
    check("t1_exp", timer_irq, 1'b1);
    bus_read(8'hB1, rd); check("t1_ctrl", rd, 16'h0000);
    bus_read(8'hB0, rd); check("t1_cnt", rd, 16'h0000);
    bus_read(8'hB2, rd); check("t1_stat", rd, 16'h0001);
    bus_write(8'hB2, 16'h0001);
    check("t1_clr", timer_irq, 1'b0);

    // Auto-reload: expiries at +12 and +24; clear on the second expiry loses
    bus_write(8'hB0, 16'd3);
    bus_write(8'hB1, 16'h0003);
    repeat (11) @(negedge clk_50MHz);
    check("t2_pre", timer_irq, 1'b0);
    @(negedge clk_50MHz);
    check("t2_exp", timer_irq, 1'b1);
    bus_write(8'hB2, 16'h0001);
    check("t2_clr", timer_irq, 1'b0);
    repeat (8) @(negedge clk_50MHz);
    bus_write(8'hB2, 16'h0001);
    check("t2_setwins", timer_irq, 1'b1);
    bus_read(8'hB0, rd); check("t2_reload", rd, 16'd3);
`else
    bus_write(8'hB1, 16'h0003);
    repeat (12) @(negedge clk_50MHz);
    check("not_irq", timer_irq, 1'b0);
`endif

    // Reset in mid-operation
    @(negedge clk_50MHz); reset = 1'b1;
    @(negedge clk_50MHz);
    check("mrst_ledr", LEDR, 10'h000);
    check("mrst_an", an_n, 4'b1110);
    check("mrst_seg", seg_n, 7'b1000000);
    check("mrst_din", DIN, 16'h0000);
    check("mrst_irq", timer_irq, 1'b0);
    reset = 1'b0;
    bus_read(8'h90, rd); check("mrst_hex", rd, 16'h0000);
`ifdef IO_TIMER_EN
    bus_read(8'hB1, rd); check("mrst_tctrl", rd, 16'h0000);
    bus_read(8'hB0, rd); check("mrst_tcnt", rd, 16'h0000);
`else
    bus_write(8'hB0, 16'h0005);
    bus_read(8'hB0, rd); check("not_b0", rd, 16'h0000);
    bus_read(8'hB2, rd); check("not_b2", rd, 16'h0000);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
